mult_rr_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit shift-add multiplier datapath between two requesters. The datapath is the register unit plus the 9-bit adder. The block arbitrates between the requesters, captures the winner's operands, and drives the datapath load, clear, add/subtract and shift strobes for a full signed multiply. It returns the 16-bit product to the winning requester with a one-cycle done pulse. It replaces push-button sequencing when the multiplier sits behind internal masters rather than switches.

---
 rtl/mult_rr_sched.sv | 134 +++++++++++++
 tb/tb_mult_rr_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_sched.sv
// Two-requester round-robin front end for a shared 8-bit shift-add
// signed multiplier datapath (register unit plus 9-bit adder).
module mult_rr_sched #(
  parameter int N_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req0,
  input  logic [N_BITS-1:0]   mcand0,
  input  logic [N_BITS-1:0]   mplier0,
  input  logic                req1,
  input  logic [N_BITS-1:0]   mcand1,
  input  logic [N_BITS-1:0]   mplier1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                done0,
  output logic                done1,
  output logic [2*N_BITS-1:0] result,
  output logic                busy,
  output logic [N_BITS-1:0]   dp_sw,
  output logic                Clr_A_X,
  output logic                Ld_B,
  output logic                Ld_A_X,
  output logic                Shift_En,
  output logic                SUBTRACT,
  input  logic                M,
  input  logic [N_BITS-1:0]   A_in,
  input  logic [N_BITS-1:0]   B_in
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(N_BITS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic                ptr;
  logic                win;
  logic [N_BITS-1:0]   mc;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_inc;
  logic                any_req;
  logic                pick;

  assign any_req = req0 | req1;
  assign pick    = (req0 & req1) ? ptr : req1;
  assign cnt_inc = cnt + 1'b1;

  // The add decision follows B[0] live, so it cannot be registered.
  assign Ld_A_X  = (state == ADD) & M;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      win      <= 1'b0;
      mc       <= '0;
      cnt      <= '0;
      result   <= '0;
      busy     <= 1'b0;
      dp_sw    <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      Clr_A_X  <= 1'b0;
      Ld_B     <= 1'b0;
      Shift_En <= 1'b0;
      SUBTRACT <= 1'b0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      Clr_A_X  <= 1'b0;
      Ld_B     <= 1'b0;
      Shift_En <= 1'b0;
      SUBTRACT <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            win     <= pick;
            mc      <= pick ? mcand1 : mcand0;
            dp_sw   <= pick ? mplier1 : mplier0;
            gnt0    <= ~pick;
            gnt1    <= pick;
            Clr_A_X <= 1'b1;
            Ld_B    <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          cnt      <= '0;
          dp_sw    <= mc;
          SUBTRACT <= (LAST == '0);
          state    <= ADD;
        end
        ADD: begin
          Shift_En <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt_inc;
          if (cnt_inc == FULL) begin
            state <= DONE;
          end else begin
            // Last partial product is the sign bit: subtract it.
            SUBTRACT <= (cnt_inc == LAST);
            state    <= ADD;
          end
        end
        DONE: begin
          result <= {A_in, B_in};
          done0  <= ~win;
          done1  <= win;
          ptr    <= ~win;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Scoreboard bench for mult_rr_sched with a behavioural datapath model
// and a cycle-position monitor derived from each grant.
module tb_mult_rr_sched;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0, req1;
  logic [7:0]  mcand0, mplier0, mcand1, mplier1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] result;
  logic [7:0]  dp_sw;
  logic        Clr_A_X, Ld_B, Ld_A_X, Shift_En, SUBTRACT;
  logic        M;
  logic [7:0]  dA = '0, dB = '0;
  logic        dX = 1'b0;
  logic [8:0]  sum;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  int          glog[$];
  int          elog[$];
  logic [7:0]  op_mc0, op_mp0, op_mc1, op_mp1;
  int          mptr;

  mult_rr_sched dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .mcand0(mcand0), .mplier0(mplier0),
    .req1(req1), .mcand1(mcand1), .mplier1(mplier1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .dp_sw(dp_sw),
    .Clr_A_X(Clr_A_X), .Ld_B(Ld_B), .Ld_A_X(Ld_A_X),
    .Shift_En(Shift_En), .SUBTRACT(SUBTRACT),
    .M(M), .A_in(dA), .B_in(dB)
  );

  always #5 Clk = ~Clk;

  assign M   = dB[0];
  assign sum = SUBTRACT ? ({dA[7], dA} - {dp_sw[7], dp_sw})
                        : ({dA[7], dA} + {dp_sw[7], dp_sw});

  always_ff @(posedge Clk) begin
    if (Clr_A_X) begin
      dA <= '0;
      dX <= 1'b0;
    end
    if (Ld_B) dB <= dp_sw;
    if (Ld_A_X) {dX, dA} <= sum;
    if (Shift_En) begin
      dA <= {dX, dA[7:1]};
      dB <= {dA[0], dB[7:1]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a,
                                       input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  // Monitor: expected strobes follow from the offset since the grant.
  initial begin
    int   cyc, gcyc, k;
    bit   active, win;
    bit   ld, addc, shc, sub, busy_e, done_e;
    logic [7:0]  wmc, wmp;
    logic [15:0] held, e;
    cyc = 0; gcyc = 0; active = 0; win = 0; held = '0;
    wmc = '0; wmp = '0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Reset) begin
        active = 0;
        held = '0;
        continue;
      end
      if (gnt0 | gnt1) begin
        chk("gnt_excl", 32'(gnt0 & gnt1), 0);
        chk("gnt_while_busy", 32'(active), 0);
        active = 1;
        gcyc = cyc;
        win = gnt1;
        wmc = win ? op_mc1 : op_mc0;
        wmp = win ? op_mp1 : op_mp0;
        glog.push_back(int'(win));
      end
      k = cyc - gcyc;
      ld     = active && k == 0;
      addc   = active && k >= 1 && k <= 15 && (k % 2 == 1);
      shc    = active && k >= 2 && k <= 16 && (k % 2 == 0);
      sub    = active && k == 15;
      busy_e = active && k <= 17;
      done_e = active && k == 18;
      chk("strobes",
          32'({Clr_A_X, Ld_B, Ld_A_X, Shift_En, SUBTRACT, busy}),
          32'({ld, ld, addc & M, shc, sub, busy_e}));
      if (ld) chk("dp_sw_mplier", 32'(dp_sw), 32'(wmp));
      if (addc) chk("dp_sw_mcand", 32'(dp_sw), 32'(wmc));
      chk("done", 32'({done1, done0}),
          done_e ? (win ? 32'd2 : 32'd1) : 32'd0);
      if (done0 | done1) begin
        if (done1 ? exp1.size() == 0 : exp0.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = done1 ? exp1.pop_front() : exp0.pop_front();
          chk(done1 ? "result1" : "result0", 32'(result), 32'(e));
          held = e;
        end
      end else begin
        chk("result_hold", 32'(result), 32'(held));
      end
      if (active && k >= 18) active = 0;
    end
  end

  task automatic issue(input int id, input logic [7:0] mc,
                       input logic [7:0] mp);
    if (id == 0) begin
      mcand0 = mc; mplier0 = mp; op_mc0 = mc; op_mp0 = mp;
      req0 = 1'b1; exp0.push_back(prod(mc, mp));
    end else begin
      mcand1 = mc; mplier1 = mp; op_mc1 = mc; op_mp1 = mp;
      req1 = 1'b1; exp1.push_back(prod(mc, mp));
    end
  endtask

  task automatic wait_gnt(input int id, input bit keep);
    bit got;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge Clk);
      #1;
      if (id == 0 && gnt0) begin
        got = 1;
        if (keep) exp0.push_back(prod(op_mc0, op_mp0));
        else begin
          req0 = 1'b0; mcand0 = 8'($urandom); mplier0 = 8'($urandom);
        end
      end
      if (id == 1 && gnt1) begin
        got = 1;
        if (keep) exp1.push_back(prod(op_mc1, op_mp1));
        else begin
          req1 = 1'b0; mcand1 = 8'($urandom); mplier1 = 8'($urandom);
        end
      end
    end
    if (!got) chk(id == 0 ? "gnt0_timeout" : "gnt1_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 120 && (exp0.size() != 0 || exp1.size() != 0); i++)
      @(posedge Clk);
    chk("drain", 32'(exp0.size() + exp1.size()), 0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic check_log(input string name);
    bit ok;
    ok = (glog.size() == elog.size());
    for (int i = 0; ok && i < glog.size(); i++)
      if (glog[i] != elog[i]) ok = 0;
    chk(name, 32'(glog.size()), ok ? 32'(glog.size()) : 32'hDEAD);
    glog.delete();
    elog.delete();
  endtask

  task automatic chk_zero(input string name);
    chk(name, 32'({gnt0, gnt1, done0, done1, busy, Clr_A_X, Ld_B,
                   Ld_A_X, Shift_En, SUBTRACT}), 0);
    chk({name, "_bus"}, {dp_sw, result}, 0);
  endtask

  initial begin
    int mask;
    logic [7:0] a0, b0, a1, b1;
    Reset = 1'b0;
    req0 = 0; req1 = 0;
    mcand0 = '0; mplier0 = '0; mcand1 = '0; mplier1 = '0;
    op_mc0 = '0; op_mp0 = '0; op_mc1 = '0; op_mp1 = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk_zero("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    issue(0, 8'h07, 8'hFD);
    wait_gnt(0, 0);
    drain();
    elog.push_back(0);
    check_log("log_single0");

    issue(1, 8'h7F, 8'h7F); wait_gnt(1, 0); drain();
    issue(1, 8'h80, 8'h80); wait_gnt(1, 0); drain();
    issue(1, 8'h80, 8'h01); wait_gnt(1, 0); drain();
    elog = '{1, 1, 1};
    check_log("log_req1");

    for (int p = 0; p < 2; p++) begin
      issue(0, 8'($urandom), 8'($urandom));
      issue(1, 8'($urandom), 8'($urandom));
      fork
        wait_gnt(0, 0);
        wait_gnt(1, 0);
      join
      drain();
    end
    elog = '{0, 1, 0, 1};
    check_log("log_pairs");

    issue(1, 8'h12, 8'hE7);
    wait_gnt(1, 1);
    repeat (5) @(posedge Clk);
    #1;
    issue(0, 8'hC3, 8'h5A);
    wait_gnt(0, 0);
    wait_gnt(1, 0);
    drain();
    elog = '{1, 0, 1};
    check_log("log_nostarve");

    issue(0, 8'h55, 8'hAA);
    wait_gnt(0, 0);
    repeat (9) @(posedge Clk);
    #2;
    Reset = 1'b0;
    exp0.delete();
    #1;
    chk_zero("midreset");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    glog.delete();
    @(posedge Clk);
    #1;
    issue(0, 8'h03, 8'h05);
    wait_gnt(0, 0);
    drain();
    elog.push_back(0);
    check_log("log_after_reset");
    mptr = 1;

    for (int it = 0; it < 12; it++) begin
      mask = $urandom_range(1, 3);
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      if (mask[0]) issue(0, a0, b0);
      if (mask[1]) issue(1, a1, b1);
      fork
        if (mask[0]) wait_gnt(0, 0);
        if (mask[1]) wait_gnt(1, 0);
      join
      drain();
      if (mask == 3) begin
        elog.push_back(mptr);
        elog.push_back(1 - mptr);
      end else begin
        elog.push_back(mask - 1);
        mptr = 2 - mask;
      end
      check_log("log_random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
